l2_mem_interface: RTL and testbench

- Sits directly downstream of the L1 cache controller and serves its `read_l2` / `write_l2` requests.
- Answers the controller with `write_done` and `l2_ack`.
- Moves one 128-bit cache block to or from a 32-bit backing memory as 4 word beats, using a per-beat ready handshake.
- Write-back uses the victim tag; refill uses the request address.

---
 rtl/l2_mem_interface.sv | 137 +++++++++++++
 tb/tb_l2_mem_interface.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/l2_mem_interface.sv
// L2 memory interface: moves a 128-bit L1 block to/from 32-bit backing memory in 4 ready-handshaked beats.
// Optional watchdog: define L2_TIMEOUT_EN to abort a stalled transfer after TIMEOUT cycles and raise err.
module l2_mem_interface #(
  parameter int WORDS_PER_BLOCK = 4,
  parameter int TAG_W           = 21,
  parameter int INDEX_W         = 7,
  parameter int TIMEOUT         = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         read_l2,
  input  logic                         write_l2,
  input  logic [31:0]                  addr,
  input  logic [TAG_W-1:0]             tag_loaded,
  input  logic [32*WORDS_PER_BLOCK-1:0] wb_data,
  output logic [32*WORDS_PER_BLOCK-1:0] fill_data,
  output logic                         l2_ack,
  output logic                         write_done,
  output logic                         busy,
  output logic [2:0]                   state,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [31:0]                  mem_addr,
  output logic [31:0]                  mem_wdata,
  input  logic [31:0]                  mem_rdata,
  input  logic                         mem_ready,
  output logic                         err
);

  localparam int BLK_W = 32 * WORDS_PER_BLOCK;

  generate
    if (WORDS_PER_BLOCK != 4 || TAG_W + INDEX_W != 28 || TIMEOUT < 1) begin : g_cfg_check
      $error("l2_mem_interface: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    WB_DONE = 3'd2,
    RD      = 3'd3,
    RD_DONE = 3'd4
  } state_t;

  state_t           cur, nxt;
  logic [1:0]       beat;
  logic [31:0]      base;
  logic [BLK_W-1:0] wb_block;
  logic             beat_done;
  logic             last_beat;
  logic             timeout_hit;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^addr[3:0];

  assign mem_req    = (cur == WB) || (cur == RD);
  assign mem_we     = (cur == WB);
  assign write_done = (cur == WB_DONE);
  assign l2_ack     = (cur == RD_DONE);
  assign busy       = (cur != IDLE);
  assign state      = cur;
  assign mem_addr   = base + {28'd0, beat, 2'b00};
  assign mem_wdata  = wb_block[{beat, 5'b00000} +: 32];
  assign beat_done  = mem_req && mem_ready;
  assign last_beat  = beat_done && (beat == 2'd3);

`ifdef L2_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts consecutive stalled cycles; any completed beat or leaving WB/RD restarts it.
  assign timeout_hit = mem_req && !mem_ready && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (!mem_req || mem_ready || timeout_hit) to_cnt <= '0;
      else                                      to_cnt <= to_cnt + 1'b1;
      if (timeout_hit) err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: begin
        if (write_l2)     nxt = WB;
        else if (read_l2) nxt = RD;
      end
      WB: begin
        if (timeout_hit)    nxt = IDLE;
        else if (last_beat) nxt = WB_DONE;
      end
      WB_DONE: if (!write_l2) nxt = IDLE;
      RD: begin
        if (timeout_hit)    nxt = IDLE;
        else if (last_beat) nxt = RD_DONE;
      end
      RD_DONE: if (!read_l2) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Request operands are captured only in IDLE so the controller may change them mid-transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat      <= 2'd0;
      base      <= 32'd0;
      wb_block  <= '0;
      fill_data <= '0;
    end else if (cur == IDLE) begin
      beat <= 2'd0;
      if (write_l2) begin
        base     <= {tag_loaded, addr[INDEX_W+3:4], 4'b0000};
        wb_block <= wb_data;
      end else if (read_l2) begin
        base <= {addr[31:4], 4'b0000};
      end
    end else if (beat_done) begin
      beat <= beat + 2'd1;
      if (cur == RD) fill_data[{beat, 5'b00000} +: 32] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_l2_mem_interface.sv
// Directed bench for l2_mem_interface: a vector table for refill/write-back/priority flows plus
// hand-written sequences for stalls, reset mid-transfer, early request drop and the watchdog.
module tb_l2_mem_interface;

  localparam logic [31:0]  NC    = 32'hFFFF_FFFF;
  localparam logic [127:0] WB1   = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] WB2   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] JUNK  = 128'hDEADBEEF_CAFEF00D_0BADC0DE_12345678;
  localparam logic [127:0] FILL1 = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] FILL2 = 128'h00000004_00000003_00000002_00000001;

  logic         clk = 1'b0;
  logic         reset, read_l2, write_l2, mem_ready;
  logic [31:0]  addr, mem_rdata;
  logic [20:0]  tag_loaded;
  logic [127:0] wb_data, fill_data;
  logic         l2_ack, write_done, busy, mem_req, mem_we, err;
  logic [2:0]   state;
  logic [31:0]  mem_addr, mem_wdata;

  typedef struct {
    logic         rst, rd, wr, rdy;
    logic [31:0]  addr, rdata;
    logic [20:0]  tag;
    logic [127:0] wbd;
    logic [2:0]   e_state;
    logic         e_req, e_we, e_ack, e_done;
    logic [31:0]  e_addr, e_wdata;
    logic         c_fill;
    logic [127:0] e_fill;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  l2_mem_interface #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .read_l2(read_l2), .write_l2(write_l2), .addr(addr),
    .tag_loaded(tag_loaded), .wb_data(wb_data), .fill_data(fill_data), .l2_ack(l2_ack),
    .write_done(write_done), .busy(busy), .state(state), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, rd, wr, rdy, input logic [31:0] a, rdata,
                              input logic [20:0] tag, input logic [127:0] wbd,
                              input logic [2:0] st, input logic req, we, ack, done,
                              input logic [31:0] ea, ew);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.rdy = rdy; v.addr = a; v.rdata = rdata;
    v.tag = tag; v.wbd = wbd; v.e_state = st; v.e_req = req; v.e_we = we;
    v.e_ack = ack; v.e_done = done; v.e_addr = ea; v.e_wdata = ew;
    v.c_fill = 1'b0; v.e_fill = '0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset = v.rst; read_l2 = v.rd; write_l2 = v.wr; mem_ready = v.rdy;
    addr = v.addr; mem_rdata = v.rdata; tag_loaded = v.tag; wb_data = v.wbd;
  endtask

  task automatic checkOutput(input vec_t v, input int i);
    check($sformatf("row%0d.state", i), state, v.e_state);
    check($sformatf("row%0d.mem_req", i), mem_req, v.e_req);
    check($sformatf("row%0d.mem_we", i), mem_we, v.e_we);
    check($sformatf("row%0d.l2_ack", i), l2_ack, v.e_ack);
    check($sformatf("row%0d.write_done", i), write_done, v.e_done);
    check($sformatf("row%0d.busy", i), busy, v.e_state != 3'd0);
    check($sformatf("row%0d.err", i), err, 1'b0);
    if (v.e_addr != NC)  check($sformatf("row%0d.mem_addr", i), mem_addr, v.e_addr);
    if (v.e_wdata != NC) check($sformatf("row%0d.mem_wdata", i), mem_wdata, v.e_wdata);
    if (v.c_fill)        check($sformatf("row%0d.fill_data", i), fill_data, v.e_fill);
  endtask

  initial begin
    int cyc, first_hit, hits;

    // Reset, then a clean refill of block 0x1800 (ack after 5 edges)
    tbl.push_back(mk(1,0,0,0, 32'h0,    32'h0,  21'h0, '0, 3'd0,0,0,0,0, 32'h0,    NC));
    tbl.push_back(mk(0,1,0,1, 32'h1804, 32'h0,  21'h0, '0, 3'd3,1,0,0,0, 32'h1800, NC));
    tbl.push_back(mk(0,1,0,1, 32'h1804, 32'hA0, 21'h0, '0, 3'd3,1,0,0,0, 32'h1804, NC));
    tbl.push_back(mk(0,1,0,1, 32'h1804, 32'hA1, 21'h0, '0, 3'd3,1,0,0,0, 32'h1808, NC));
    tbl.push_back(mk(0,1,0,1, 32'h1804, 32'hA2, 21'h0, '0, 3'd3,1,0,0,0, 32'h180C, NC));
    tbl.push_back(mk(0,1,0,1, 32'h1804, 32'hA3, 21'h0, '0, 3'd4,0,0,1,0, NC,       NC));
    tbl[$].c_fill = 1'b1; tbl[$].e_fill = FILL1;
    tbl.push_back(mk(0,1,0,1, 32'h1804, 32'h0,  21'h0, '0, 3'd4,0,0,1,0, NC,       NC));
    tbl.push_back(mk(0,0,0,1, 32'h1804, 32'h0,  21'h0, '0, 3'd0,0,0,0,0, NC,       NC));
    // Dirty write-back with tag 2; operands scrambled mid-transfer must be ignored
    tbl.push_back(mk(0,0,1,1, 32'h1800,     32'h0, 21'h2,      WB1,  3'd1,1,1,0,0, 32'h1000, 32'h11));
    tbl.push_back(mk(0,0,1,1, 32'hFFFF0000, 32'h0, 21'h1FFFFF, JUNK, 3'd1,1,1,0,0, 32'h1004, 32'h22));
    tbl.push_back(mk(0,0,1,1, 32'hFFFF0000, 32'h0, 21'h1FFFFF, JUNK, 3'd1,1,1,0,0, 32'h1008, 32'h33));
    tbl.push_back(mk(0,0,1,1, 32'hFFFF0000, 32'h0, 21'h1FFFFF, JUNK, 3'd1,1,1,0,0, 32'h100C, 32'h44));
    tbl.push_back(mk(0,0,1,1, 32'hFFFF0000, 32'h0, 21'h1FFFFF, JUNK, 3'd2,0,0,0,1, NC, NC));
    tbl.push_back(mk(0,0,1,1, 32'hFFFF0000, 32'h0, 21'h1FFFFF, JUNK, 3'd2,0,0,0,1, NC, NC));
    tbl.push_back(mk(0,0,0,1, 32'hFFFF0000, 32'h0, 21'h1FFFFF, JUNK, 3'd0,0,0,0,0, NC, NC));
    tbl[$].c_fill = 1'b1; tbl[$].e_fill = FILL1;
    // Simultaneous requests: write-back first, refill once read_l2 is seen in IDLE
    tbl.push_back(mk(0,1,1,1, 32'h130, 32'h0, 21'h7, WB2, 3'd1,1,1,0,0, 32'h3930, 32'hAAAAAAAA));
    tbl.push_back(mk(0,1,1,1, 32'h130, 32'h0, 21'h7, WB2, 3'd1,1,1,0,0, 32'h3934, 32'hBBBBBBBB));
    tbl.push_back(mk(0,1,1,1, 32'h130, 32'h0, 21'h7, WB2, 3'd1,1,1,0,0, 32'h3938, 32'hCCCCCCCC));
    tbl.push_back(mk(0,1,1,1, 32'h130, 32'h0, 21'h7, WB2, 3'd1,1,1,0,0, 32'h393C, 32'hDDDDDDDD));
    tbl.push_back(mk(0,1,1,1, 32'h130, 32'h0, 21'h7, WB2, 3'd2,0,0,0,1, NC, NC));
    tbl.push_back(mk(0,1,0,1, 32'h130, 32'h0, 21'h7, WB2, 3'd0,0,0,0,0, NC, NC));
    tbl.push_back(mk(0,1,0,1, 32'h130, 32'h0, 21'h7, WB2, 3'd3,1,0,0,0, 32'h130, NC));
    tbl.push_back(mk(0,1,0,1, 32'h130, 32'h1, 21'h7, WB2, 3'd3,1,0,0,0, 32'h134, NC));
    tbl.push_back(mk(0,1,0,1, 32'h130, 32'h2, 21'h7, WB2, 3'd3,1,0,0,0, 32'h138, NC));
    tbl.push_back(mk(0,1,0,1, 32'h130, 32'h3, 21'h7, WB2, 3'd3,1,0,0,0, 32'h13C, NC));
    tbl.push_back(mk(0,1,0,1, 32'h130, 32'h4, 21'h7, WB2, 3'd4,0,0,1,0, NC, NC));
    tbl[$].c_fill = 1'b1; tbl[$].e_fill = FILL2;
    tbl.push_back(mk(0,0,0,1, 32'h130, 32'h0, 21'h7, WB2, 3'd0,0,0,0,0, NC, NC));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkOutput(tbl[i], i);
    end

    // Three stall cycles before every beat: ack expected on edge 17
    read_l2 = 1'b1; addr = 32'h0000_4008; mem_ready = 1'b0; mem_rdata = 32'h0;
    cyc = 0; first_hit = 0;
    tick(); cyc++;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 3; s++) begin
        check($sformatf("stall.addr%0d_%0d", k, s), mem_addr, 32'h4000 + 32'(4 * k));
        mem_ready = 1'b0;
        tick(); cyc++;
        if (l2_ack && first_hit == 0) first_hit = cyc;
      end
      mem_ready = 1'b1; mem_rdata = 32'hB0 + 32'(k);
      tick(); cyc++;
      if (l2_ack && first_hit == 0) first_hit = cyc;
    end
    mem_ready = 1'b0;
    check("stall.ack_cycle", first_hit, 17);
    check("stall.fill", fill_data, 128'h000000B3_000000B2_000000B1_000000B0);
    read_l2 = 1'b0;
    tick();
    check("stall.idle", state, 3'd0);

    // write_l2 dropped right after being sampled: one-cycle write_done on edge 5
    write_l2 = 1'b1; tag_loaded = 21'h3; addr = 32'h0; wb_data = JUNK; mem_ready = 1'b1;
    cyc = 0; first_hit = 0; hits = 0;
    tick(); cyc++;
    write_l2 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(); cyc++;
      if (write_done) begin
        hits++;
        if (first_hit == 0) first_hit = cyc;
      end
    end
    check("drop.done_cycle", first_hit, 5);
    check("drop.done_len", hits, 1);
    check("drop.idle", state, 3'd0);

    // Reset while the refill is on beat 2
    read_l2 = 1'b1; addr = 32'h0000_8000; mem_ready = 1'b1; mem_rdata = 32'h55;
    tick(); tick(); tick();
    check("rst_mid.addr", mem_addr, 32'h8008);
    reset = 1'b1; read_l2 = 1'b0;
    tick();
    check("rst_mid.state", state, 3'd0);
    check("rst_mid.mem_req", mem_req, 1'b0);
    check("rst_mid.fill", fill_data, 128'h0);
    check("rst_mid.busy", busy, 1'b0);
    reset = 1'b0; hits = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (l2_ack) hits++;
    end
    check("rst_mid.no_ack", hits, 0);

`ifdef L2_TIMEOUT_EN
    // Memory never ready: watchdog fires on the 8th stalled cycle
    read_l2 = 1'b1; addr = 32'h0000_2000; mem_ready = 1'b0;
    tick();
    for (int c = 1; c < 8; c++) begin
      tick();
      check($sformatf("wdog.err_early%0d", c), err, 1'b0);
    end
    tick();
    check("wdog.err", err, 1'b1);
    check("wdog.mem_req", mem_req, 1'b0);
    check("wdog.state", state, 3'd0);
    check("wdog.l2_ack", l2_ack, 1'b0);
`else
    // Without the watchdog a stalled refill simply waits
    read_l2 = 1'b1; addr = 32'h0000_2000; mem_ready = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    check("wait.state", state, 3'd3);
    check("wait.mem_req", mem_req, 1'b1);
    check("wait.err", err, 1'b0);
`endif
    read_l2 = 1'b0; reset = 1'b1;
    tick();
    check("final.err", err, 1'b0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
